// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue controller: opcodes, unit count,
// controller states and the opcode-to-start-vector mapping.
package fpu_pkg;

  localparam int N_UNITS = 9;

  localparam logic [3:0] OP_ADD_SUB = 4'd1;
  localparam logic [3:0] OP_MUL     = 4'd2;
  localparam logic [3:0] OP_DIV     = 4'd3;
  localparam logic [3:0] OP_SQRT    = 4'd4;
  localparam logic [3:0] OP_SIGN    = 4'd5;
  localparam logic [3:0] OP_COMP    = 4'd6;
  localparam logic [3:0] OP_I2F     = 4'd7;
  localparam logic [3:0] OP_F2I     = 4'd8;
  localparam logic [3:0] OP_MAC     = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Opcode k selects unit k-1; opcodes with no unit map to an all-zero vector.
  function automatic logic [N_UNITS-1:0] op_to_onehot(input logic [3:0] op);
    logic [N_UNITS-1:0] v;
    v = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (op == 4'(i + 1)) begin
        v[i] = 1'b1;
      end else begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/fpu_op_decode.sv
// Combinational opcode decoder: legality flag plus one-hot unit select.
// Shared between the issue controller and the result-mux side.
module fpu_op_decode
  import fpu_pkg::*;
(
  input  logic [3:0]         i_op,
  output logic               o_legal,
  output logic [N_UNITS-1:0] o_onehot
);

  logic [N_UNITS-1:0] w_onehot;

  assign w_onehot = op_to_onehot(i_op);
  assign o_onehot = w_onehot;
  assign o_legal  = |w_onehot;

endmodule

// File: rtl/fpu_dispatch.sv
// FPU issue controller: accepts one request, pulses the target unit's start,
// waits (with timeout) for its done and returns the muxed result.
module fpu_dispatch #(
  parameter int W              = 32,
  parameter int N_UNITS        = fpu_pkg::N_UNITS,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_op,
  input  logic [W-1:0]       req_a,
  input  logic [W-1:0]       req_b,
  input  logic [W-1:0]       req_c,
  output logic [N_UNITS-1:0] unit_start,
  output logic [W-1:0]       unit_a,
  output logic [W-1:0]       unit_b,
  output logic [W-1:0]       unit_c,
  input  logic [N_UNITS-1:0] unit_done,
  output logic [3:0]         mux_sel,
  input  logic [W-1:0]       muxed_result,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [W-1:0]       resp_data,
  output logic               resp_err,
  output logic               busy
);
  import fpu_pkg::*;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic               w_legal;
  logic [N_UNITS-1:0] w_onehot;
  logic               w_done_hit;

  state_t             r_state;
  logic [N_UNITS-1:0] r_onehot;
  logic               r_legal;
  logic [TW-1:0]      r_timer;
  logic               r_req_ready;
  logic [N_UNITS-1:0] r_unit_start;
  logic [W-1:0]       r_unit_a;
  logic [W-1:0]       r_unit_b;
  logic [W-1:0]       r_unit_c;
  logic [3:0]         r_mux_sel;
  logic               r_resp_valid;
  logic [W-1:0]       r_resp_data;
  logic               r_resp_err;
  logic               r_busy;

  fpu_op_decode u_decode (
    .i_op     (req_op),
    .o_legal  (w_legal),
    .o_onehot (w_onehot)
  );

  // Only the done line of the unit that was started can complete the operation.
  assign w_done_hit = |(unit_done & r_onehot);

  assign req_ready  = r_req_ready;
  assign unit_start = r_unit_start;
  assign unit_a     = r_unit_a;
  assign unit_b     = r_unit_b;
  assign unit_c     = r_unit_c;
  assign mux_sel    = r_mux_sel;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_err   = r_resp_err;
  assign busy       = r_busy;

  // Controller state machine with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_onehot     <= '0;
      r_legal      <= 1'b0;
      r_timer      <= '0;
      r_req_ready  <= 1'b0;
      r_unit_start <= '0;
      r_unit_a     <= '0;
      r_unit_b     <= '0;
      r_unit_c     <= '0;
      r_mux_sel    <= 4'd0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid && r_req_ready) begin
            r_req_ready  <= 1'b0;
            r_busy       <= 1'b1;
            r_unit_a     <= req_a;
            r_unit_b     <= req_b;
            r_unit_c     <= req_c;
            r_onehot     <= w_onehot;
            r_unit_start <= w_onehot;
            r_legal      <= w_legal;
            r_mux_sel    <= w_legal ? req_op : 4'd0;
            r_state      <= ISSUE;
          end else begin
            r_req_ready  <= 1'b1;
          end
        end
        // Illegal opcodes pass through ISSUE without a start pulse.
        ISSUE: begin
          r_unit_start <= '0;
          r_timer      <= '0;
          if (r_legal) begin
            r_state      <= WAIT;
          end else begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b1;
            r_mux_sel    <= 4'd0;
            r_state      <= RESP;
          end
        end
        WAIT: begin
          if (w_done_hit) begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= muxed_result;
            r_resp_err   <= 1'b0;
            r_mux_sel    <= 4'd0;
            r_state      <= RESP;
          end else if (r_timer == TIMER_LAST) begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b1;
            r_mux_sel    <= 4'd0;
            r_state      <= RESP;
          end else begin
            r_timer      <= r_timer + TW'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
            r_busy       <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end else begin
            r_resp_valid <= 1'b1;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_unit_start <= '0;
          r_mux_sel    <= 4'd0;
          r_resp_valid <= 1'b0;
          r_resp_data  <= '0;
          r_resp_err   <= 1'b0;
          r_busy       <= 1'b0;
          r_req_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_dispatch.sv
// Self-checking bench for fpu_dispatch: a timeline model of each transaction
// checked every cycle, plus directed scenarios with literal expectations.
module tb_fpu_dispatch;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_a = 32'd0, req_b = 32'd0, req_c = 32'd0;
  logic [8:0]  unit_start;
  logic [31:0] unit_a, unit_b, unit_c;
  logic [8:0]  unit_done = 9'd0;
  logic [3:0]  mux_sel;
  logic [31:0] muxed_result = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  fpu_dispatch #(.W(32), .N_UNITS(9), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .unit_start(unit_start), .unit_a(unit_a), .unit_b(unit_b), .unit_c(unit_c),
    .unit_done(unit_done), .mux_sel(mux_sel), .muxed_result(muxed_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction timeline model: handshake cycle, response start cycle, data.
  int          cyc = 0;
  int          m_ths = 0;
  int          m_tresp = -1;
  bit          m_active = 1'b0;
  bit          m_ready_ok = 1'b0;
  bit          m_legal = 1'b0;
  logic [3:0]  m_op = 4'd0;
  logic [31:0] m_a = 32'd0, m_b = 32'd0, m_c = 32'd0, m_data = 32'd0;
  logic        m_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active   = 1'b0;
      m_ready_ok = 1'b0;
      m_tresp    = -1;
    end else begin
      if (m_active) begin
        if (m_tresp >= 0 && cyc >= m_tresp) begin
          if (resp_ready) m_active = 1'b0;
        end else if (m_legal && cyc >= m_ths + 2) begin
          if (unit_done[m_op - 4'd1]) begin
            m_tresp = cyc + 1; m_data = muxed_result; m_err = 1'b0;
          end else if (cyc == m_ths + 2 + TO - 1) begin
            m_tresp = cyc + 1; m_data = 32'd0; m_err = 1'b1;
          end
        end
      end else if (m_ready_ok && req_valid) begin
        m_active = 1'b1;
        m_ths    = cyc;
        m_op     = req_op;
        m_a = req_a; m_b = req_b; m_c = req_c;
        m_legal  = (req_op >= 4'd1) && (req_op <= 4'd9);
        if (m_legal) begin
          m_tresp = -1;
        end else begin
          m_tresp = cyc + 2; m_data = 32'd0; m_err = 1'b1;
        end
      end
      m_ready_ok = 1'b1;
      cyc++;
    end
  end

  logic       e_rv;
  logic [8:0] e_start;
  logic [3:0] e_mux;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);  chk("rst_busy", busy, 0);
      chk("rst_start", unit_start, 0);     chk("rst_mux", mux_sel, 0);
      chk("rst_valid", resp_valid, 0);     chk("rst_data", resp_data, 0);
      chk("rst_err", resp_err, 0);         chk("rst_a", unit_a, 0);
      chk("rst_b", unit_b, 0);             chk("rst_c", unit_c, 0);
    end else begin
      e_rv    = m_active && m_tresp >= 0 && cyc >= m_tresp;
      e_start = (m_active && m_legal && cyc == m_ths + 1) ? (9'b1 << (m_op - 4'd1)) : 9'd0;
      e_mux   = (m_active && m_legal && cyc >= m_ths + 1 && !e_rv) ? m_op : 4'd0;
      chk("req_ready", req_ready, (!m_active && m_ready_ok) ? 1 : 0);
      chk("busy", busy, m_active ? 1 : 0);
      chk("unit_start", unit_start, e_start);
      chk("mux_sel", mux_sel, e_mux);
      chk("resp_valid", resp_valid, e_rv);
      if (e_rv) begin
        chk("resp_data", resp_data, m_data);
        chk("resp_err", resp_err, m_err);
      end
      if (m_active && cyc >= m_ths + 1) begin
        chk("unit_a", unit_a, m_a); chk("unit_b", unit_b, m_b); chk("unit_c", unit_c, m_c);
      end
    end
  end

  task automatic send_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c);
    int k;
    req_op = op; req_a = a; req_b = b; req_c = c; req_valid = 1'b1;
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin
      @(posedge clk); #2; k++;
    end
    if (k >= 20) begin
      n_cmp++; n_bad++;
      $display("FAIL req_accept: req_ready never rose at %0t", $time);
    end
    @(posedge clk); #2;
    req_valid = 1'b0; req_op = 4'd0;
    req_a = ~a; req_b = ~b; req_c = ~c;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input int done_at, input logic [31:0] result,
                       input int exp_lat, input logic [31:0] exp_data, input logic exp_err,
                       input logic [8:0] exp_start, input bit stray, input int rr_delay,
                       input bit pulse_resp, input bit poke);
    int lat;
    logic [8:0] d;
    send_req(op, a, b, c);
    chk("issue_start_lit", unit_start, exp_start);
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 100) begin
      d = 9'd0;
      muxed_result = 32'hDEADBEEF;
      if (stray && lat - 2 >= 2 && lat - 2 <= 5) d = 9'h101;
      if (done_at >= 0 && lat - 2 == done_at) begin
        d = d | (9'b1 << (op - 4'd1));
        muxed_result = result;
      end
      unit_done = d;
      @(posedge clk); #2; lat++;
    end
    unit_done = 9'd0; muxed_result = 32'd0;
    chk("resp_latency_lit", lat, exp_lat);
    chk("resp_data_lit", resp_data, exp_data);
    chk("resp_err_lit", resp_err, exp_err);
    for (int i = 0; i < rr_delay; i++) begin
      if (pulse_resp && i < 2) begin
        unit_done = 9'b1 << (op - 4'd1); muxed_result = 32'h12345678;
      end else begin
        unit_done = 9'd0; muxed_result = 32'd0;
      end
      if (poke) begin
        req_valid = 1'b1; req_op = 4'd1;
      end
      @(posedge clk); #2;
      chk("bp_valid_lit", resp_valid, 1);
      chk("bp_data_lit", resp_data, exp_data);
      chk("bp_err_lit", resp_err, exp_err);
      chk("bp_req_ready_lit", req_ready, 0);
    end
    unit_done = 9'd0; muxed_result = 32'd0; req_valid = 1'b0; req_op = 4'd0;
    resp_ready = 1'b1;
    @(posedge clk); #2;
    resp_ready = 1'b0;
    chk("resp_drop_lit", resp_valid, 0);
    chk("ready_back_lit", req_ready, 1);
    chk("idle_busy_lit", busy, 0);
  endtask

  initial begin
    int seen;
    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      req_valid = 1'($urandom); req_op = 4'($urandom); req_a = $urandom;
      req_b = $urandom; req_c = $urandom; unit_done = 9'($urandom);
      muxed_result = $urandom; resp_ready = 1'($urandom);
    end
    @(posedge clk); #2;
    req_valid = 1'b0; req_op = 4'd0; req_a = 32'd0; req_b = 32'd0; req_c = 32'd0;
    unit_done = 9'd0; muxed_result = 32'd0; resp_ready = 1'b0;
    rst_n = 1'b1;
    #1 chk("release_ready_low_lit", req_ready, 0);
    @(posedge clk); #2;
    chk("release_ready_high_lit", req_ready, 1);
    chk("release_busy_lit", busy, 0);

    do_op(4'd2, 32'h40000000, 32'h40400000, 32'h0, 0, 32'h40C00000,
          3, 32'h40C00000, 1'b0, 9'h002, 1'b0, 0, 1'b0, 1'b0);
    do_op(4'd3, 32'h3F800000, 32'h40000000, 32'h0, 20, 32'h3F000000,
          23, 32'h3F000000, 1'b0, 9'h004, 1'b1, 0, 1'b0, 1'b0);
    do_op(4'hA, 32'h11111111, 32'h22222222, 32'h33333333, -1, 32'h0,
          2, 32'h0, 1'b1, 9'h000, 1'b0, 0, 1'b0, 1'b0);
    do_op(4'd4, 32'h40000000, 32'h0, 32'h0, -1, 32'h0,
          66, 32'h0, 1'b1, 9'h008, 1'b0, 4, 1'b1, 1'b0);
    do_op(4'd4, 32'h40000000, 32'h0, 32'h0, 63, 32'h3FB504F3,
          66, 32'h3FB504F3, 1'b0, 9'h008, 1'b0, 0, 1'b0, 1'b0);
    do_op(4'd9, 32'h40000000, 32'h40A00000, 32'h3F800000, 1, 32'h41300000,
          4, 32'h41300000, 1'b0, 9'h100, 1'b0, 5, 1'b0, 1'b1);
    do_op(4'd0, 32'h5, 32'h6, 32'h7, -1, 32'h0,
          2, 32'h0, 1'b1, 9'h000, 1'b0, 1, 1'b0, 1'b0);

    // Reset in the middle of WAIT abandons the operation.
    send_req(4'd2, 32'hAAAA5555, 32'h5555AAAA, 32'h0F0F0F0F);
    repeat (10) begin
      @(posedge clk); #2;
    end
    chk("pre_reset_busy_lit", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_busy_lit", busy, 0);       chk("async_mux_lit", mux_sel, 0);
    chk("async_a_lit", unit_a, 0);        chk("async_ready_lit", req_ready, 0);
    chk("async_valid_lit", resp_valid, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      unit_done = (i == 5) ? 9'h002 : 9'd0;
      @(posedge clk); #2;
      if (resp_valid === 1'b1) seen++;
    end
    unit_done = 9'd0;
    chk("no_resp_after_reset_lit", seen, 0);

    do_op(4'd1, 32'h3F800000, 32'h3F800000, 32'h0, 0, 32'h40000000,
          3, 32'h40000000, 1'b0, 9'h001, 1'b0, 0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
